// File: rtl/interleaver_pkg.sv
// interleaver_pkg: bank-state type, {bank,row,col} address packing and sizing helpers
// shared by the block interleaver controller and its output FIFO.
package interleaver_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    localparam int DEF_W    = 8;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    function automatic int lg2(input int n);
        return $clog2(n);
    endfunction

    // Bank is the MSB, then row, then column; callers truncate to their address width.
    function automatic logic [31:0] pack_addr(input logic bank, input int row, input int col,
                                              input int rb, input int cb);
        return (32'(bank) << (rb + cb)) | (32'(row) << cb) | 32'(col);
    endfunction

endpackage

// File: rtl/ilv_out_fifo2.sv
// ilv_out_fifo2: two-entry output FIFO absorbing RAM read data under downstream backpressure.
module ilv_out_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_ready_i,
    output logic         pop_valid_o,
    output logic [W-1:0] pop_data_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         pop;

    assign pop_valid_o = cnt_q != 2'd0;
    assign pop_data_o  = mem_q[rp_q];
    assign occ_o       = cnt_q;
    assign pop         = pop_valid_o && pop_ready_i;
    assign cnt_d       = cnt_q + {1'b0, push_i} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= push_data_i;
                wp_q        <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/block_interleaver_ctrl.sv
// block_interleaver_ctrl: ping-pong block interleaver; writes blocks row-major into one RAM bank
// while the other bank is read back column-major through a two-entry output FIFO.
module block_interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int AW   = 1 + lg2(ROWS) + lg2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [W-1:0]  ram_wdata,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [W-1:0]  ram_rdata,
    output logic          blk_done
);
    localparam int RB = lg2(ROWS);
    localparam int CB = lg2(COLS);
    localparam int N  = ROWS * COLS;
    localparam int NB = lg2(N);

    bank_state_t   bank_q [2];
    bank_state_t   bank_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic [RB-1:0] wr_row_q, wr_row_d;
    logic [CB-1:0] wr_col_q, wr_col_d;
    logic          rd_bank_q, rd_bank_d;
    logic [RB-1:0] rd_row_q, rd_row_d;
    logic [CB-1:0] rd_col_q, rd_col_d;
    logic          issued_q, issued_d;
    logic [NB-1:0] out_cnt_q, out_cnt_d;
    logic          inflight_q;

    logic          wr_fire;
    logic          wr_last;
    logic          rd_last;
    logic          rd_busy;
    logic          out_fire;
    logic [1:0]    items;
    logic          credit;
    logic          f_push;
    logic          f_valid;
    logic [W-1:0]  f_data;
    logic [1:0]    f_occ;

    assign in_ready = !rst && (bank_q[wr_bank_q] == EMPTY || bank_q[wr_bank_q] == FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_row_q == RB'(ROWS - 1) && wr_col_q == CB'(COLS - 1);

    assign ram_we    = wr_fire;
    assign ram_wdata = wr_fire ? in_data : '0;
    assign ram_waddr = wr_fire ? AW'(pack_addr(wr_bank_q, int'(wr_row_q), int'(wr_col_q), RB, CB)) : '0;

    // The head is the FIFO when it holds data, otherwise RAM data arriving this cycle is bypassed.
    assign out_valid = !rst && (f_valid || inflight_q);
    assign out_data  = out_valid ? (f_valid ? f_data : ram_rdata) : '0;
    assign out_fire  = out_valid && out_ready;
    assign f_push    = inflight_q && (f_valid || !out_ready);

    assign rd_last  = rd_row_q == RB'(ROWS - 1) && rd_col_q == CB'(COLS - 1);
    assign rd_busy  = bank_q[rd_bank_q] == FULL || (bank_q[rd_bank_q] == DRAINING && !issued_q);
    assign items    = f_occ + {1'b0, inflight_q};
    assign credit   = (items - {1'b0, out_fire}) < 2'd2;
    assign ram_re   = !rst && rd_busy && credit;
    assign ram_raddr = ram_re ? AW'(pack_addr(rd_bank_q, int'(rd_row_q), int'(rd_col_q), RB, CB)) : '0;
    assign blk_done = out_fire && out_cnt_q == NB'(N - 1);

    // Power-of-two dimensions let the counters wrap to zero on their own at the last cell.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        issued_d  = issued_q;
        out_cnt_d = out_fire ? out_cnt_q + NB'(1) : out_cnt_q;
        if (wr_fire) begin
            wr_col_d  = wr_col_q + CB'(1);
            wr_row_d  = wr_col_q == CB'(COLS - 1) ? wr_row_q + RB'(1) : wr_row_q;
            wr_bank_d = wr_last ? ~wr_bank_q : wr_bank_q;
        end
        if (ram_re) begin
            rd_row_d = rd_row_q + RB'(1);
            rd_col_d = rd_row_q == RB'(ROWS - 1) ? rd_col_q + CB'(1) : rd_col_q;
            issued_d = rd_last;
        end
        if (blk_done) begin
            rd_bank_d = ~rd_bank_q;
            issued_d  = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire && wr_bank_q == 1'(b)) bank_d[b] = wr_last ? FULL : FILLING;
            if (ram_re && rd_bank_q == 1'(b) && bank_q[b] == FULL) bank_d[b] = DRAINING;
            if (blk_done && rd_bank_q == 1'(b)) bank_d[b] = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q     <= '{EMPTY, EMPTY};
            wr_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            issued_q   <= 1'b0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_bank_q  <= wr_bank_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            rd_bank_q  <= rd_bank_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            issued_q   <= issued_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= ram_re;
        end
    end

    ilv_out_fifo2 #(
        .W(W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (f_push),
        .push_data_i(ram_rdata),
        .pop_ready_i(out_ready),
        .pop_valid_o(f_valid),
        .pop_data_o (f_data),
        .occ_o      (f_occ)
    );

endmodule

// File: tb/tb_block_interleaver_ctrl.sv
// tb_block_interleaver_ctrl: drives the interleaver with a 1-cycle-latency RAM model and compares
// its output stream with a column-major permutation of the symbols sent.
module tb_block_interleaver_ctrl;
    localparam int W = 8, ROWS = 4, COLS = 4, AW = 5, BLK = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, ram_we, ram_re, blk_done;
    logic [W-1:0]  out_data, ram_wdata;
    logic [W-1:0]  ram_rdata = '0;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [W-1:0]  mem [2**AW];

    int checks = 0, errors = 0;
    logic [W-1:0] in_q[$], got_q[$];
    int done_cnt, done_bad, stable_viol, first_stall, t_last_in, t_first_ov, first_waddr, coincide;

    block_interleaver_ctrl #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .blk_done(blk_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    // Output k of a block is input (row = k mod ROWS, col = k div ROWS) of that block.
    function automatic logic [W-1:0] exp_at(input int i);
        int k = i % BLK;
        return in_q[(i / BLK) * BLK + (k % ROWS) * COLS + k / ROWS];
    endfunction

    task automatic run(input int from, input int n_out, input int in_pct, input int rdy_pct,
                       input int hold_at, input int budget);
        int sent = from;
        bit held = 0;
        bit prev_stall = 0;
        logic [W-1:0] prev_d = '0;
        done_cnt = 0; done_bad = 0; stable_viol = 0; coincide = 0;
        first_stall = -1; t_last_in = -1; t_first_ov = -1; first_waddr = -1;
        for (int c = 0; c < budget; c++) begin
            if (sent >= in_q.size() && got_q.size() >= n_out) break;
            in_valid = sent < in_q.size() && !(sent == hold_at && !held) && $urandom_range(99) < in_pct;
            in_data = sent < in_q.size() ? in_q[sent] : '0;
            out_ready = $urandom_range(99) < rdy_pct;
            @(negedge clk);
            if (sent == hold_at) held = 1;
            if (prev_stall && out_valid && out_data !== prev_d) stable_viol++;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            if (out_valid && t_first_ov < 0) t_first_ov = c;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (blk_done) begin
                done_cnt++;
                if (!(out_valid && out_ready && got_q.size() % BLK == 0)) done_bad++;
            end
            if (in_valid && in_ready) begin
                if (first_waddr < 0) first_waddr = int'(ram_waddr);
                if (sent % BLK == BLK - 1 && blk_done) coincide++;
                sent++;
                if (sent == in_q.size()) t_last_in = c;
            end else if (in_valid && first_stall < 0) first_stall = sent;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, ram_we, ram_re, blk_done, out_data, ram_wdata, ram_waddr, ram_raddr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b re=%b rdy=%b ov=%b waddr=%0d expected all zero", ram_we, ram_re, in_ready, out_valid, ram_waddr);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_block();
        int bad = 0;
        in_q.delete(); got_q.delete();
        for (int i = 0; i < BLK; i++) in_q.push_back(W'(i));
        run(0, BLK, 100, 100, -1, 200);
        checks++;
        if (got_q.size() != BLK) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), BLK); end
        for (int i = 0; i < got_q.size() && i < BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
        checks++;
        if (t_first_ov - t_last_in != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", t_first_ov - t_last_in); end
        checks++;
        if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL single_blk_done: got %0d pulses %0d misplaced expected 1 0", done_cnt, done_bad); end
        for (int i = 0; i < BLK; i++) if (mem[i] !== W'(i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL single_ram_layout: got %0d wrong cells expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        in_q.delete(); got_q.delete();
        for (int i = 0; i < 3 * BLK; i++) in_q.push_back(W'(i));
        run(0, 3 * BLK, 100, 100, -1, 400);
        checks++;
        if (got_q.size() != 3 * BLK) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), 3 * BLK); end
        for (int i = 0; i < got_q.size() && i < 3 * BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
        checks++;
        if (done_cnt != 3 || done_bad != 0) begin errors++; $display("FAIL b2b_blk_done: got %0d pulses %0d misplaced expected 3 0", done_cnt, done_bad); end
        checks++;
        if (first_stall >= 0 && first_stall < 2 * BLK) begin errors++; $display("FAIL b2b_in_ready: got stall at input %0d expected none before %0d", first_stall, 2 * BLK); end
    endtask

    task automatic test_backpressure(input int nblk, input int in_pct, input int rdy_pct, input bit rnd_data);
        in_q.delete(); got_q.delete();
        for (int i = 0; i < nblk * BLK; i++) in_q.push_back(rnd_data ? W'($urandom) : W'(i));
        run(0, nblk * BLK, in_pct, rdy_pct, -1, 3000);
        checks++;
        if (got_q.size() != nblk * BLK) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), nblk * BLK); end
        for (int i = 0; i < got_q.size() && i < nblk * BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
        checks++;
        if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stable_viol); end
        checks++;
        if (done_cnt != nblk || done_bad != 0) begin errors++; $display("FAIL bp_blk_done: got %0d pulses %0d misplaced expected %0d 0", done_cnt, done_bad, nblk); end
    endtask

    task automatic test_both_full();
        int n = 0;
        in_q.delete(); got_q.delete();
        for (int i = 0; i < 2 * BLK; i++) in_q.push_back(W'($urandom));
        run(0, 0, 100, 0, -1, 200);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_at(0)) begin errors++; $display("FAIL full_head: got valid=%b data=%0d expected 1 %0d", out_valid, out_data, exp_at(0)); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && n < BLK; c++) begin
            @(negedge clk);
            if (out_valid) begin got_q.push_back(out_data); n++; end
        end
        checks++;
        if (n != BLK) begin errors++; $display("FAIL full_drain: got %0d outputs expected %0d", n, BLK); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at_done: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_done: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        run(2 * BLK, 2 * BLK, 100, 100, -1, 200);
        checks++;
        if (got_q.size() != 2 * BLK) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), 2 * BLK); end
        for (int i = 0; i < got_q.size() && i < 2 * BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL full_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
    endtask

    task automatic test_reset_mid();
        in_q.delete(); got_q.delete();
        for (int i = 0; i < BLK + 9; i++) in_q.push_back(W'($urandom));
        run(0, BLK / 2, 100, 100, -1, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, ram_we, ram_re, blk_done, out_data, ram_waddr, ram_raddr} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got rdy=%b ov=%b re=%b data=%0d expected all zero", in_ready, out_valid, ram_re, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, ram_re} !== 3'b100) begin errors++; $display("FAIL midrst_flush: got rdy=%b ov=%b re=%b expected 1 0 0", in_ready, out_valid, ram_re); end
        @(posedge clk); #1;
        in_q.delete(); got_q.delete();
        for (int i = 0; i < BLK; i++) in_q.push_back(W'(100 + i));
        run(0, BLK, 100, 100, -1, 200);
        checks++;
        if (first_waddr != 0) begin errors++; $display("FAIL midrst_bank0: got first waddr %0d expected 0", first_waddr); end
        checks++;
        if (got_q.size() != BLK || done_cnt != 1) begin errors++; $display("FAIL midrst_count: got %0d outputs %0d pulses expected %0d 1", got_q.size(), done_cnt, BLK); end
        for (int i = 0; i < got_q.size() && i < BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL midrst_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
    endtask

    task automatic test_simul_handoff();
        in_q.delete(); got_q.delete();
        for (int i = 0; i < 3 * BLK; i++) in_q.push_back(W'($urandom));
        run(0, 3 * BLK, 100, 100, BLK, 400);
        checks++;
        if (coincide != 1) begin errors++; $display("FAIL handoff_coincide: got %0d expected 1", coincide); end
        checks++;
        if (first_stall != -1) begin errors++; $display("FAIL handoff_stall: got stall at input %0d expected none", first_stall); end
        checks++;
        if (got_q.size() != 3 * BLK || done_cnt != 3 || done_bad != 0) begin
            errors++;
            $display("FAIL handoff_count: got %0d outputs %0d pulses %0d misplaced expected %0d 3 0", got_q.size(), done_cnt, done_bad, 3 * BLK);
        end
        for (int i = 0; i < got_q.size() && i < 3 * BLK; i++) begin
            checks++;
            if (got_q[i] !== exp_at(i)) begin errors++; $display("FAIL handoff_data[%0d]: got %0d expected %0d", i, got_q[i], exp_at(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure(2, 100, 50, 1'b0);
        test_backpressure(3, 70, 60, 1'b1);
        test_both_full();
        test_reset_mid();
        test_simul_handoff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
